kbd_scan_ctrl: RTL and testbench
================================

# kbd_scan_ctrl

Sequencing controller between the PS/2 byte receiver and the scan-code-to-ASCII lookup. Decodes the prefix protocol (E0 extended, F0 break) with an FSM and tracks modifier state (left/right shift, ctrl, caps lock). Drives the shared combinational lookup with the code and effective shift, then queues complete key events in an output FIFO for the consumer (display/terminal logic).

## Interface
Parameters:
- DEPTH, 8: event FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  scan byte available from receiver.
- in_data  in  8  scan byte.
- in_ready  out  1  byte accepted when in_valid & in_ready; equals !fifo_full.
- lk_code  out  8  scan code presented to lookup; equals in_data.
- lk_shift  out  1  effective shift presented to lookup (shift_o).
- lk_ascii  in  8  combinational lookup result, same cycle.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer pops when ev_valid & ev_ready.
- ev_data  out  19  {brk, ext, ctrl, scan[7:0], ascii[7:0]} of head entry.
- shift_o  out  1  left or right shift held.
- ctrl_o  out  1  left or right ctrl held.
- caps_o  out  1  caps-lock latch.
- key_cnt  out  8  count of make events queued, wraps 255→0.

## Operation
- FSM states: IDLE, EXT, BRK, EXT_BRK. Advances only on an accepted byte.
  - IDLE: E0→EXT; F0→BRK; else process make (ext=0) and stay.
  - EXT: F0→EXT_BRK; E0 stays EXT; else process make (ext=1)→IDLE.
  - BRK: F0 stays; E0→EXT_BRK; else process break (ext=0)→IDLE.
  - EXT_BRK: E0/F0 stay; else process break (ext=1)→IDLE.
  - 00 or FF (keyboard error) in any state: →IDLE, no event, no state change.
- Modifiers consume the byte and produce no event:
  - 12 (ext=0) sets/clears shift_l; 59 sets/clears shift_r.
  - 14 with ext=0 drives ctrl_l; with ext=1 drives ctrl_r.
  - 58: a make toggles caps only when caps_held=0, then sets caps_held; a break clears caps_held. Typematic repeats therefore do not re-toggle.
- All other codes push one event: brk, ext, ctrl=ctrl_o, scan=code, ascii=A.
  - A = lk_ascii with bit 5 inverted when caps_o=1 and lk_ascii is in 41–5A or 61–7A. Otherwise A = lk_ascii; unmapped codes give 00.
  - Break events are pushed with the same ascii computation.
- key_cnt increments by 1 on every pushed event with brk=0.
- in_ready=0 when FIFO full. Modifier and prefix bytes are also stalled while full; no internal bypass.
- Simultaneous push and pop: allowed at any occupancy below full; occupancy unchanged.

## Timing
- Reset values: FSM=IDLE; FIFO empty; ev_valid=0; ev_data=0; in_ready=1; shift_o, ctrl_o, caps_o, caps_held=0; key_cnt=0.
- Byte accepted in cycle N → event visible on ev_valid/ev_data in N+1 (empty FIFO). Modifier outputs update in N+1.
- Lookup is combinational within cycle N. lk_shift reflects state before the byte, so a modifier byte never affects its own lookup.
- Pop in cycle N → next head at N+1. in_ready rises in the cycle after a pop from full.
- Reset asserted mid-sequence (e.g. after F0): FSM returns to IDLE, all queued events are discarded, and the next byte is treated as unprefixed.

## Configuration
- KBD_CAPSLOCK_EN defined: caps latch, caps_held, and letter case inversion as above.
- KBD_CAPSLOCK_EN undefined: code 58 pushes a normal event, caps_o is tied 0, and ascii equals lk_ascii.

## Structure
- Package kbd_pkg holds:
  - state enum {IDLE, EXT, BRK, EXT_BRK};
  - constants SC_EXT=E0, SC_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CTRL=14, SC_CAPS=58;
  - packed struct kbd_event_t (19 bits, field order as ev_data).
- Sub-module kbd_evt_fifo: synchronous DEPTH×19 FIFO with full/empty flags and pointer-wrap via an extra MSB.

## Test plan
- Bytes 1C → ev_data={0,0,0,1C,61}, key_cnt=1; then F0 1C → {1,0,0,1C,61}, key_cnt still 1.
- 12, 1C, F0 12, 1C → events ascii 41 then 61; shift_o 1 then 0; no event for 12.
- (CAPS_EN) 58, 58 (repeat), 1C, 16 → caps_o=1 after both 58s, events 41 and 31; then F0 58, 58 → caps_o=0.
- E0 14, E0 75, E0 F0 14 → ctrl_o=1; event {0,1,1,75,lk}; ctrl_o=0 afterward.
- ev_ready=0, nine 1C makes with DEPTH=8 → in_ready low after the 8th, 9th held by source; drain → 8 events in order, then the 9th accepted.
- F0, then rst_n pulse, then 1C → make event brk=0, FIFO contains only it.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the keyboard scan controller.
//   kbd_state_e  - prefix-decoder FSM states
//   SC_*         - scan-code constants for prefixes and modifier keys
//   kbd_event_t  - queued key event, {brk, ext, ctrl, scan, ascii} (19 bits)
//   apply_caps() - letter case inversion used when caps lock is active
// Optional feature macro: KBD_CAPSLOCK_EN (see kbd_scan_ctrl).
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic       ctrl;
        logic [7:0] scan;
        logic [7:0] ascii;
    } kbd_event_t;

    // Flip bit 5 of ASCII letters only; digits and punctuation pass through.
    function automatic logic [7:0] apply_caps(input logic caps, input logic [7:0] a);
        if (caps && (((a >= 8'h41) && (a <= 8'h5A)) || ((a >= 8'h61) && (a <= 8'h7A)))) begin
            return a ^ 8'h20;
        end
        return a;
    endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// kbd_evt_fifo: synchronous DEPTH x kbd_event_t FIFO.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data (ignored while full)
//   push_data   - event to enqueue
//   pop         - drop head entry (ignored while empty)
//   head        - head entry, all-zero while empty
//   full, empty - occupancy flags
// Pointers carry one extra MSB so full and empty are distinguishable when the
// index bits match.
module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  kbd_event_t push_data,
    input  logic       pop,
    output kbd_event_t head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_q, rd_q;
    kbd_event_t  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: PS/2 scan-byte sequencer. Decodes E0/F0 prefixes, tracks
// shift/ctrl/caps modifiers, drives the external ASCII lookup and queues key
// events in an output FIFO.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - scan byte handshake (in_ready = FIFO not full)
//   in_data             - scan byte
//   lk_code, lk_shift   - lookup request (code, effective shift before byte)
//   lk_ascii            - combinational lookup result
//   ev_valid/ev_ready   - event handshake; ev_data = {brk,ext,ctrl,scan,ascii}
//   shift_o, ctrl_o     - either side held
//   caps_o              - caps-lock latch
//   key_cnt             - make events queued, wraps at 8 bits
// Macro KBD_CAPSLOCK_EN: enables caps latch and letter case inversion; when
// undefined, code 58 is an ordinary key and caps_o is tied low.
module kbd_scan_ctrl
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [7:0]  lk_code,
    output logic        lk_shift,
    input  logic [7:0]  lk_ascii,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [18:0] ev_data,
    output logic        shift_o,
    output logic        ctrl_o,
    output logic        caps_o,
    output logic [7:0]  key_cnt
);

    kbd_state_e state_q, state_d;
    logic       shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic       ctrl_l_q, ctrl_l_d, ctrl_r_q, ctrl_r_d;
    logic [7:0] key_cnt_q, key_cnt_d;
    logic       accept, cur_brk, cur_ext;
    logic       push, full, empty;
    kbd_event_t push_data, head;

`ifdef KBD_CAPSLOCK_EN
    logic caps_q, caps_d, caps_held_q, caps_held_d;
    assign caps_o = caps_q;
`else
    assign caps_o = 1'b0;
`endif

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign lk_code  = in_data;
    assign shift_o  = shift_l_q || shift_r_q;
    assign ctrl_o   = ctrl_l_q || ctrl_r_q;
    assign lk_shift = shift_o;
    assign key_cnt  = key_cnt_q;
    assign cur_brk  = (state_q == BRK) || (state_q == EXT_BRK);
    assign cur_ext  = (state_q == EXT) || (state_q == EXT_BRK);

    always_comb begin
        state_d   = state_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        ctrl_l_d  = ctrl_l_q;
        ctrl_r_d  = ctrl_r_q;
        key_cnt_d = key_cnt_q;
`ifdef KBD_CAPSLOCK_EN
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
`endif
        push      = 1'b0;
        push_data = '{brk: cur_brk, ext: cur_ext, ctrl: ctrl_o, scan: in_data,
                      ascii: apply_caps(caps_o, lk_ascii)};

        if (accept) begin
            if ((in_data == SC_ERR0) || (in_data == SC_ERR1)) begin
                // Keyboard error: abandon any partial prefix sequence.
                state_d = IDLE;
            end else if (in_data == SC_EXT) begin
                state_d = cur_brk ? EXT_BRK : EXT;
            end else if (in_data == SC_BRK) begin
                state_d = cur_ext ? EXT_BRK : BRK;
            end else begin
                state_d = IDLE;
                if ((in_data == SC_LSHIFT) && !cur_ext) begin
                    shift_l_d = !cur_brk;
                end else if (in_data == SC_RSHIFT) begin
                    shift_r_d = !cur_brk;
                end else if (in_data == SC_CTRL) begin
                    if (cur_ext) ctrl_r_d = !cur_brk;
                    else         ctrl_l_d = !cur_brk;
                end
`ifdef KBD_CAPSLOCK_EN
                else if (in_data == SC_CAPS) begin
                    // Toggle only on the first make so typematic repeats are inert.
                    if (cur_brk) begin
                        caps_held_d = 1'b0;
                    end else begin
                        if (!caps_held_q) caps_d = !caps_q;
                        caps_held_d = 1'b1;
                    end
                end
`endif
                else begin
                    push = 1'b1;
                    if (!cur_brk) key_cnt_d = key_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
            ctrl_l_q  <= 1'b0;
            ctrl_r_q  <= 1'b0;
            key_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            shift_l_q <= shift_l_d;
            shift_r_q <= shift_r_d;
            ctrl_l_q  <= ctrl_l_d;
            ctrl_r_q  <= ctrl_r_d;
            key_cnt_q <= key_cnt_d;
        end
    end

`ifdef KBD_CAPSLOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
        end else begin
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
        end
    end
`endif

    kbd_evt_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_data),
        .pop      (ev_ready),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    assign ev_valid = !empty;
    assign ev_data  = head;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Testbench for kbd_scan_ctrl: table-driven byte vectors plus hand-written
// sequences for counter wrap, FIFO full back-pressure and mid-sequence reset.
module tb_kbd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  lk_code;
    logic        lk_shift;
    logic [7:0]  lk_ascii;
    logic        ev_valid;
    logic        ev_ready;
    logic [18:0] ev_data;
    logic        shift_o, ctrl_o, caps_o;
    logic [7:0]  key_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kbd_scan_ctrl #(
        .DEPTH(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .lk_code (lk_code),
        .lk_shift(lk_shift),
        .lk_ascii(lk_ascii),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_data (ev_data),
        .shift_o (shift_o),
        .ctrl_o  (ctrl_o),
        .caps_o  (caps_o),
        .key_cnt (key_cnt)
    );

    // Small stand-in for the scan-code-to-ASCII table.
    always_comb begin
        case (lk_code)
            8'h1C:   lk_ascii = lk_shift ? 8'h41 : 8'h61;
            8'h32:   lk_ascii = lk_shift ? 8'h42 : 8'h62;
            8'h16:   lk_ascii = lk_shift ? 8'h21 : 8'h31;
            8'h29:   lk_ascii = 8'h20;
            default: lk_ascii = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0]  b;
        logic        p;
        logic [18:0] e;
        logic        s;
        logic        c;
        logic        k;
        logic [7:0]  n;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [18:0] ev(input logic brk, input logic ext, input logic ctl,
                                       input logic [7:0] scan, input logic [7:0] asc);
        return {brk, ext, ctl, scan, asc};
    endfunction

    function automatic vec_t v(input logic [7:0] b, input logic p, input logic [18:0] e,
                               input logic s, input logic c, input logic k,
                               input logic [7:0] n);
        vec_t r;
        r.b = b; r.p = p; r.e = e; r.s = s; r.c = c; r.k = k; r.n = n;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] fc [9];
        logic [7:0] exp_cnt;
        int         nwrap;

        fc = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

        vecs.push_back(v(8'h1C, 1, ev(0, 0, 0, 8'h1C, 8'h61), 0, 0, 0, 8'd1));
        vecs.push_back(v(8'hF0, 0, '0,                          0, 0, 0, 8'd1));
        vecs.push_back(v(8'h1C, 1, ev(1, 0, 0, 8'h1C, 8'h61), 0, 0, 0, 8'd1));
        vecs.push_back(v(8'h12, 0, '0,                          1, 0, 0, 8'd1));
        vecs.push_back(v(8'h1C, 1, ev(0, 0, 0, 8'h1C, 8'h41), 1, 0, 0, 8'd2));
        vecs.push_back(v(8'hF0, 0, '0,                          1, 0, 0, 8'd2));
        vecs.push_back(v(8'h12, 0, '0,                          0, 0, 0, 8'd2));
        vecs.push_back(v(8'h1C, 1, ev(0, 0, 0, 8'h1C, 8'h61), 0, 0, 0, 8'd3));
        vecs.push_back(v(8'hE0, 0, '0,                          0, 0, 0, 8'd3));
        vecs.push_back(v(8'h14, 0, '0,                          0, 1, 0, 8'd3));
        vecs.push_back(v(8'hE0, 0, '0,                          0, 1, 0, 8'd3));
        vecs.push_back(v(8'h75, 1, ev(0, 1, 1, 8'h75, 8'h00), 0, 1, 0, 8'd4));
        vecs.push_back(v(8'hE0, 0, '0,                          0, 1, 0, 8'd4));
        vecs.push_back(v(8'hF0, 0, '0,                          0, 1, 0, 8'd4));
        vecs.push_back(v(8'h14, 0, '0,                          0, 0, 0, 8'd4));
        vecs.push_back(v(8'h59, 0, '0,                          1, 0, 0, 8'd4));
        vecs.push_back(v(8'h16, 1, ev(0, 0, 0, 8'h16, 8'h21), 1, 0, 0, 8'd5));
        vecs.push_back(v(8'hF0, 0, '0,                          1, 0, 0, 8'd5));
        vecs.push_back(v(8'h59, 0, '0,                          0, 0, 0, 8'd5));
        vecs.push_back(v(8'hF0, 0, '0,                          0, 0, 0, 8'd5));
        vecs.push_back(v(8'hFF, 0, '0,                          0, 0, 0, 8'd5));
        vecs.push_back(v(8'hE0, 0, '0,                          0, 0, 0, 8'd5));
        vecs.push_back(v(8'h00, 0, '0,                          0, 0, 0, 8'd5));
        vecs.push_back(v(8'h1C, 1, ev(0, 0, 0, 8'h1C, 8'h61), 0, 0, 0, 8'd6));
        vecs.push_back(v(8'hE0, 0, '0,                          0, 0, 0, 8'd6));
        vecs.push_back(v(8'h12, 1, ev(0, 1, 0, 8'h12, 8'h00), 0, 0, 0, 8'd7));
`ifdef KBD_CAPSLOCK_EN
        vecs.push_back(v(8'h58, 0, '0,                          0, 0, 1, 8'd7));
        vecs.push_back(v(8'h58, 0, '0,                          0, 0, 1, 8'd7));
        vecs.push_back(v(8'h1C, 1, ev(0, 0, 0, 8'h1C, 8'h41), 0, 0, 1, 8'd8));
        vecs.push_back(v(8'h16, 1, ev(0, 0, 0, 8'h16, 8'h31), 0, 0, 1, 8'd9));
        vecs.push_back(v(8'hF0, 0, '0,                          0, 0, 1, 8'd9));
        vecs.push_back(v(8'h58, 0, '0,                          0, 0, 1, 8'd9));
        vecs.push_back(v(8'h58, 0, '0,                          0, 0, 0, 8'd9));
        vecs.push_back(v(8'hF0, 0, '0,                          0, 0, 0, 8'd9));
        vecs.push_back(v(8'h58, 0, '0,                          0, 0, 0, 8'd9));
`else
        vecs.push_back(v(8'h58, 1, ev(0, 0, 0, 8'h58, 8'h00), 0, 0, 0, 8'd8));
        vecs.push_back(v(8'hF0, 0, '0,                          0, 0, 0, 8'd8));
        vecs.push_back(v(8'h58, 1, ev(1, 0, 0, 8'h58, 8'h00), 0, 0, 0, 8'd8));
`endif

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        ev_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_ev_data", {13'd0, ev_data}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_shift", {31'd0, shift_o}, 32'd0);
        chk("rst_ctrl", {31'd0, ctrl_o}, 32'd0);
        chk("rst_caps", {31'd0, caps_o}, 32'd0);
        chk("rst_key_cnt", {24'd0, key_cnt}, 32'd0);

        exp_cnt = 8'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].b);
            chk($sformatf("v%0d_ev_valid", i), {31'd0, ev_valid}, {31'd0, vecs[i].p});
            if (vecs[i].p) begin
                chk($sformatf("v%0d_ev_data", i), {13'd0, ev_data}, {13'd0, vecs[i].e});
                pop1();
            end
            chk($sformatf("v%0d_shift", i), {31'd0, shift_o}, {31'd0, vecs[i].s});
            chk($sformatf("v%0d_ctrl", i), {31'd0, ctrl_o}, {31'd0, vecs[i].c});
            chk($sformatf("v%0d_caps", i), {31'd0, caps_o}, {31'd0, vecs[i].k});
            chk($sformatf("v%0d_key_cnt", i), {24'd0, key_cnt}, {24'd0, vecs[i].n});
            exp_cnt = vecs[i].n;
        end

        // key_cnt wraps 255 -> 0; consumer pops continuously meanwhile.
        nwrap    = 256 - int'(exp_cnt);
        ev_ready = 1'b1;
        for (int i = 0; i < nwrap - 1; i++) send(8'h1C);
        chk("wrap_cnt_255", {24'd0, key_cnt}, 32'd255);
        send(8'h1C);
        chk("wrap_cnt_0", {24'd0, key_cnt}, 32'd0);
        @(negedge clk);
        ev_ready = 1'b0;
        chk("wrap_drained", {31'd0, ev_valid}, 32'd0);

        // Fill to DEPTH, hold the ninth byte under back-pressure, then drain.
        for (int i = 0; i < 8; i++) send(fc[i]);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_head", {13'd0, ev_data}, {13'd0, ev(0, 0, 0, fc[0], 8'h00)});
        in_valid = 1'b1;
        in_data  = fc[8];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
        end
        chk("stall_key_cnt", {24'd0, key_cnt}, 32'd8);
        pop1();
        chk("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ninth_full_again", {31'd0, in_ready}, 32'd0);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("drain%0d_valid", i), {31'd0, ev_valid}, 32'd1);
            chk($sformatf("drain%0d_data", i), {13'd0, ev_data},
                {13'd0, ev(0, 0, 0, fc[i], 8'h00)});
            pop1();
        end
        chk("drain_empty", {31'd0, ev_valid}, 32'd0);
        chk("drain_key_cnt", {24'd0, key_cnt}, 32'd9);

        // Reset after a queued event and a dangling F0.
        send(8'h1C);
        send(8'hF0);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("midrst_ev_data", {13'd0, ev_data}, 32'd0);
        chk("midrst_key_cnt", {24'd0, key_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h1C);
        chk("postrst_valid", {31'd0, ev_valid}, 32'd1);
        chk("postrst_data", {13'd0, ev_data}, {13'd0, ev(0, 0, 0, 8'h1C, 8'h61)});
        pop1();
        chk("postrst_only_one", {31'd0, ev_valid}, 32'd0);
        chk("postrst_key_cnt", {24'd0, key_cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
